// File: rtl/m_shiftseq_pkg.sv
// m_shiftseq_pkg
//   Shared definitions for the multi-cycle shift sequencer: FSM state
//   encodings, shift-op encodings and small decode helpers used by both the
//   control block (m_shiftseq) and its datapath (m_shiftseq_dp).
//   No ports (package).
package m_shiftseq_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

  // Shift-op encodings; 2'b10 is reserved and behaves as a logical right shift
  localparam logic [1:0] SHOP_SLL  = 2'b00;
  localparam logic [1:0] SHOP_SRL  = 2'b01;
  localparam logic [1:0] SHOP_RSVD = 2'b10;
  localparam logic [1:0] SHOP_SRA  = 2'b11;

  // Every op other than SLL moves bits towards the LSB
  function automatic logic shop_is_right(input logic [1:0] op);
    return (op == SHOP_SRL) || (op == SHOP_SRA) || (op == SHOP_RSVD);
  endfunction

  // Only SRA replicates the sign bit into the vacated positions
  function automatic logic shop_is_arith(input logic [1:0] op);
    return (op == SHOP_SRA);
  endfunction

endpackage

// File: rtl/m_shiftseq_dp.sv
// m_shiftseq_dp
//   Datapath of the shift sequencer: operand register, fill-bit select,
//   1-bit (and optionally 4-bit) shift step mux and capture of the last bit
//   shifted out.
//   Build option: M_SHIFTSEQ_NIBBLE_EN adds the 4-bit step path and the
//   step4 select input; without it only the 1-bit step exists.
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   load      in   capture b/shop, clear lastout
//   shift_en  in   perform one shift step this cycle
//   step4     in   (M_SHIFTSEQ_NIBBLE_EN only) use a 4-bit step
//   b         in   operand to capture
//   shop      in   shift op to capture
//   opnd      out  operand / shifted word register
//   lastout   out  last bit shifted out
module m_shiftseq_dp #(
  parameter int ALUWIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                shift_en,
`ifdef M_SHIFTSEQ_NIBBLE_EN
  input  logic                step4,
`endif
  input  logic [ALUWIDTH-1:0] b,
  input  logic [1:0]          shop,
  output logic [ALUWIDTH-1:0] opnd,
  output logic                lastout
);
  import m_shiftseq_pkg::*;

  logic [1:0]          op_q;
  logic                right;
  logic                fill;
  logic [ALUWIDTH-1:0] shift_1;
  logic                out_1;
  logic [ALUWIDTH-1:0] next_opnd;
  logic                next_last;

  // The op is latched with the operand so later changes on shop are harmless
  assign right = shop_is_right(op_q);
  assign fill  = shop_is_arith(op_q) & opnd[ALUWIDTH-1];

  // Single-bit step: the bit falling off the end becomes the new lastout
  assign shift_1 = right ? {fill, opnd[ALUWIDTH-1:1]} : {opnd[ALUWIDTH-2:0], 1'b0};
  assign out_1   = right ? opnd[0] : opnd[ALUWIDTH-1];

`ifdef M_SHIFTSEQ_NIBBLE_EN
  logic [ALUWIDTH-1:0] shift_4;
  logic                out_4;

  // Four-bit step: the last of the four bits to leave is the one kept
  assign shift_4 = right ? {{4{fill}}, opnd[ALUWIDTH-1:4]} : {opnd[ALUWIDTH-5:0], 4'b0000};
  assign out_4   = right ? opnd[3] : opnd[ALUWIDTH-4];

  assign next_opnd = step4 ? shift_4 : shift_1;
  assign next_last = step4 ? out_4 : out_1;
`else
  assign next_opnd = shift_1;
  assign next_last = out_1;
`endif

  // Operand, op and lastout registers. A load restarts the result from the
  // raw operand with lastout cleared, so a zero-length shift reports 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd    <= '0;
      op_q    <= SHOP_SLL;
      lastout <= 1'b0;
    end else if (load) begin
      opnd    <= b;
      op_q    <= shop;
      lastout <= 1'b0;
    end else if (shift_en) begin
      opnd    <= next_opnd;
      lastout <= next_last;
    end
  end

endmodule

// File: rtl/m_shiftseq.sv
// m_shiftseq
//   Multi-cycle shift sequencer placed after the ALU result bus. Captures B,
//   shifts it by shamt one bit per cycle (four per cycle while possible when
//   M_SHIFTSEQ_NIBBLE_EN is defined) and presents the result on a
//   ready/valid port. Holds the FSM, shift counter and handshake; the
//   shifting itself lives in m_shiftseq_dp.
//   Build option: M_SHIFTSEQ_NIBBLE_EN enables 4-bit steps.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   B          in   ALU result, captured on an accepted start
//   start      in   request, accepted when start & in_ready
//   shop       in   00 SLL, 01 SRL, 11 SRA, 10 reserved (SRL)
//   shamt      in   shift amount
//   in_ready   out  high in IDLE
//   busy       out  high in SHIFT
//   res_valid  out  result valid, held until consumed
//   res_ready  in   consumer accepts the result
//   result     out  shifted word
//   lastout    out  last bit shifted out, 0 for a zero-length shift
module m_shiftseq #(
  parameter  int ALUWIDTH = 8,
  localparam int SHW      = $clog2(ALUWIDTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ALUWIDTH-1:0] B,
  input  logic                start,
  input  logic [1:0]          shop,
  input  logic [SHW-1:0]      shamt,
  output logic                in_ready,
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [ALUWIDTH-1:0] result,
  output logic                lastout
);
  import m_shiftseq_pkg::*;

  state_t         state;
  logic [SHW-1:0] count;
  logic [SHW-1:0] step_amt;
  logic           accept;
  logic           shift_en;

  // Both flags decode straight from the state register
  assign in_ready = (state == IDLE);
  assign busy     = (state == SHIFT);
  assign accept   = start & in_ready;
  assign shift_en = (state == SHIFT);

`ifdef M_SHIFTSEQ_NIBBLE_EN
  logic step4;

  // Take the wide step only while it cannot overshoot the remaining count
  assign step4    = shift_en && (count >= SHW'(4));
  assign step_amt = step4 ? SHW'(4) : SHW'(1);
`else
  assign step_amt = SHW'(1);
`endif

  m_shiftseq_dp #(
    .ALUWIDTH (ALUWIDTH)
  ) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .shift_en (shift_en),
`ifdef M_SHIFTSEQ_NIBBLE_EN
    .step4    (step4),
`endif
    .b        (B),
    .shop     (shop),
    .opnd     (result),
    .lastout  (lastout)
  );

  // Control FSM. res_valid is raised one cycle after DONE is entered so the
  // final shift has settled in the datapath register before it is offered.
  // Consumption sends the block to IDLE on that same edge, so a start seen
  // in the consuming cycle is not accepted; the next cycle is the earliest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            count <= shamt;
            state <= (shamt != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          count <= count - step_amt;
          if (count == step_amt) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!res_valid) begin
            res_valid <= 1'b1;
          end else if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_shiftseq.sv
// tb_m_shiftseq
//   Self-checking bench for m_shiftseq at ALUWIDTH=8. A table of directed
//   vectors is run through start/valid/ready transactions, followed by
//   hand-written backpressure and mid-operation reset sequences. Expected
//   latency follows the M_SHIFTSEQ_NIBBLE_EN build option.
module tb_m_shiftseq;

  logic       clk;
  logic       rst_n;
  logic [7:0] B;
  logic       start;
  logic [1:0] shop;
  logic [2:0] shamt;
  logic       in_ready;
  logic       busy;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] result;
  logic       lastout;

  int checks;
  int failures;

  typedef struct {
    logic [7:0] b;
    logic [1:0] shop;
    logic [2:0] shamt;
    logic [7:0] exp_res;
    logic       exp_last;
  } vec_t;

  vec_t vecs[10];

  m_shiftseq #(
    .ALUWIDTH (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .B         (B),
    .start     (start),
    .shop      (shop),
    .shamt     (shamt),
    .in_ready  (in_ready),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .lastout   (lastout)
  );

  // 10 time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles from the accepting edge to the edge that raises res_valid
  function automatic int expLatency(input int n);
`ifdef M_SHIFTSEQ_NIBBLE_EN
    return 1 + (n / 4) + (n % 4);
`else
    return 1 + n;
`endif
  endfunction

  // One comparison: counts it, and reports a FAIL line on mismatch
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Issues one start and waits (bounded) for res_valid; lat=-1 on timeout
  task automatic applyStimulus(input string tag, input logic [7:0] b, input logic [1:0] op,
                               input logic [2:0] n, output int lat);
    @(negedge clk);
    B     = b;
    shop  = op;
    shamt = n;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    B     = ~b;
    checkOutput({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'(n != 3'd0));
    lat = -1;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk);
      #1;
      if (res_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  // Accepts the result and checks the block is idle again right afterwards
  task automatic consume(input string tag);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    checkOutput({tag, "_valid_dropped"}, 32'(res_valid), 32'd0);
    checkOutput({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    string tag;

    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    B         = 8'h00;
    start     = 1'b0;
    shop      = 2'b00;
    shamt     = 3'd0;
    res_ready = 1'b0;

    // b, shop, shamt, expected result, expected lastout
    vecs[0] = '{8'h81, 2'b00, 3'd1, 8'h02, 1'b1};
    vecs[1] = '{8'h80, 2'b11, 3'd7, 8'hFF, 1'b0};
    vecs[2] = '{8'h80, 2'b01, 3'd7, 8'h01, 1'b0};
    vecs[3] = '{8'h5A, 2'b00, 3'd0, 8'h5A, 1'b0};
    vecs[4] = '{8'hF0, 2'b01, 3'd5, 8'h07, 1'b1};
    vecs[5] = '{8'h0F, 2'b00, 3'd4, 8'hF0, 1'b0};
    vecs[6] = '{8'hB4, 2'b11, 3'd3, 8'hF6, 1'b1};
    vecs[7] = '{8'hC3, 2'b10, 3'd2, 8'h30, 1'b1};
    vecs[8] = '{8'hA5, 2'b00, 3'd6, 8'h40, 1'b1};
    vecs[9] = '{8'h7F, 2'b11, 3'd6, 8'h01, 1'b1};

    // Reset state
    #12;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_lastout", 32'(lastout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven transactions
    for (int i = 0; i < 10; i++) begin
      tag = $sformatf("vec%0d", i);
      applyStimulus(tag, vecs[i].b, vecs[i].shop, vecs[i].shamt, lat);
      checkOutput({tag, "_latency"}, 32'(lat), 32'(expLatency(int'(vecs[i].shamt))));
      checkOutput({tag, "_result"}, 32'(result), 32'(vecs[i].exp_res));
      checkOutput({tag, "_lastout"}, 32'(lastout), 32'(vecs[i].exp_last));
      consume(tag);
    end

    // Backpressure: result held, in_ready low, stray start ignored
    applyStimulus("bp", 8'h80, 2'b01, 3'd7, lat);
    checkOutput("bp_latency", 32'(lat), 32'(expLatency(7)));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 2) begin
        B     = 8'hFF;
        shop  = 2'b00;
        shamt = 3'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp_hold%0d_result", c), 32'(result), 32'h01);
      checkOutput($sformatf("bp_hold%0d_in_ready", c), 32'(in_ready), 32'd0);
      checkOutput($sformatf("bp_hold%0d_valid", c), 32'(res_valid), 32'd1);
    end
    // Start coinciding with consumption must not be accepted
    @(negedge clk);
    start     = 1'b1;
    B         = 8'h33;
    shamt     = 3'd2;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    res_ready = 1'b0;
    checkOutput("bp_consume_in_ready", 32'(in_ready), 32'd1);
    checkOutput("bp_consume_busy", 32'(busy), 32'd0);
    checkOutput("bp_consume_valid", 32'(res_valid), 32'd0);
    // Accepted on the very next cycle
    applyStimulus("bp_next", 8'h81, 2'b00, 3'd1, lat);
    checkOutput("bp_next_latency", 32'(lat), 32'(expLatency(1)));
    checkOutput("bp_next_result", 32'(result), 32'h02);
    checkOutput("bp_next_lastout", 32'(lastout), 32'd1);
    consume("bp_next");

    // Reset during the third shift cycle of a 6-bit shift
    @(negedge clk);
    B     = 8'hFF;
    shop  = 2'b00;
    shamt = 3'd6;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_valid", 32'(res_valid), 32'd0);
    checkOutput("mid_rst_result", 32'(result), 32'd0);
    checkOutput("mid_rst_lastout", 32'(lastout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("post_rst", 8'hB4, 2'b11, 3'd3, lat);
    checkOutput("post_rst_latency", 32'(lat), 32'(expLatency(3)));
    checkOutput("post_rst_result", 32'(result), 32'hF6);
    checkOutput("post_rst_lastout", 32'(lastout), 32'd1);
    consume("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
